nonce_report_tx: RTL and testbench
==================================

NONCE_REPORT_TX -- requirements
Module: nonce_report_tx

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of SHA256 cores whose flags are monitored.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, nonce buffer entries; power of two, range 2..16.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flag  input  NUM_CORES  per-core golden-nonce-found flags from the output manager.
REQ-006 SHALL have port golden_nonce  input  32  nonce selected by the output manager.
REQ-007 SHALL have port tx_ready  input  1  downstream byte sink ready.
REQ-008 SHALL have port tx_data  output  8  current byte presented.
REQ-009 SHALL have port tx_valid  output  1  tx_data is valid.
REQ-010 SHALL have port fifo_full  output  1  buffer holds FIFO_DEPTH entries.
REQ-011 SHALL have port drop_count  output  8  count of nonces lost to overflow.
REQ-012 SHALL have port busy  output  1  buffer non-empty or a frame is in progress.

Function
REQ-013 SHALL form hit = OR of all flag bits and register it as hit_q every cycle.
REQ-014 SHALL capture golden_nonce into the FIFO on the cycle where hit=1 and hit_q=0 (rising edge); a flag held high SHALL produce one entry only.
REQ-015 SHALL, when a capture occurs with FIFO full and no pop in the same cycle, discard the nonce and increment drop_count, saturating at 255.
REQ-016 SHALL accept a capture when full if a pop occurs in the same cycle; count unchanged, no drop.
REQ-017 SHALL implement read/write pointers wrapping modulo FIFO_DEPTH, with an occupancy counter 0..FIFO_DEPTH; fifo_full = (occupancy==FIFO_DEPTH).
REQ-018 SHALL implement FSM states IDLE, LOAD, SEND.
REQ-019 IDLE: tx_valid=0; to LOAD when occupancy>0.
REQ-020 LOAD: pop head entry into a 32-bit shift register, reset byte index to 0, to SEND next cycle; occupancy decrements in this cycle.
REQ-021 SEND: tx_valid=1, tx_data = current byte, most significant byte first (bits 31:24 first).
REQ-022 A byte SHALL transfer on a cycle with tx_valid=1 and tx_ready=1; tx_data SHALL remain stable while tx_valid=1 and tx_ready=0.
REQ-023 After the last byte of a frame transfers, SHALL go to LOAD if occupancy>0 else IDLE (one idle cycle between frames via LOAD).
REQ-024 Minimum latency: capture edge at cycle N -> first byte valid at N+3 when FIFO was empty and FSM in IDLE.
REQ-025 busy = (occupancy>0) or (state != IDLE).

Reset
REQ-026 On n_rst=0, asynchronously: state IDLE, pointers and occupancy 0, hit_q 0, drop_count 0, tx_valid 0, tx_data 0x00, fifo_full 0, busy 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame and discard all buffered nonces; no partial frame resumes after release.
REQ-028 On release with flag already high, hit_q=0 SHALL cause one capture on the first active edge.

Configuration
REQ-029 Macro NONCE_REPORT_HEADER_EN defined: each frame SHALL be 5 bytes, header byte 0xA5 first, then the 4 nonce bytes MSB first; latency of first nonce byte becomes N+4.
REQ-030 Macro NONCE_REPORT_HEADER_EN undefined: frame SHALL be exactly 4 nonce bytes, no header, no header logic.

Verification
REQ-031 Empty buffer, tx_ready=1, flag=2'b01 pulse with golden_nonce=0xDEADBEEF -> bytes DE,AD,BE,EF on 4 consecutive cycles starting cycle N+3 (with header: A5 first at N+3).
REQ-032 flag held high 10 cycles with nonce 0x12345678 -> exactly one frame 12,34,56,78; drop_count stays 0.
REQ-033 tx_ready=0, six distinct nonce pulses, FIFO_DEPTH=4 -> first nonce in shift register, four buffered, sixth dropped, fifo_full=1, drop_count=1; then tx_ready=1 -> five frames in capture order.
REQ-034 FIFO full and capture coincident with LOAD pop -> nonce accepted, drop_count unchanged, frame order preserved.
REQ-035 n_rst asserted after second byte of frame 0xCAFEF00D with two nonces queued -> tx_valid=0 immediately, busy=0, drop_count=0; after release no further bytes without new flag.
REQ-036 300 overflow drops -> drop_count saturates at 255.

Source files
------------

// File: rtl/nonce_report_tx_if.sv
// nonce_report_tx_if: byte-stream handshake between the nonce reporter and its byte sink.
//   tx_data  : current byte presented by the master
//   tx_valid : tx_data is valid
//   tx_ready : sink accepts the byte this cycle
//   master modport is the nonce_report_tx side; slave is the byte sink side.
interface nonce_report_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/nonce_report_tx.sv
// nonce_report_tx: buffers golden nonces found by the SHA256 cores and streams each one out as a byte frame.
//   clk          : system clock, all state on the rising edge
//   n_rst        : asynchronous active-low reset
//   flag         : per-core golden-nonce-found flags; their OR is edge-detected to capture a nonce
//   golden_nonce : nonce selected by the output manager
//   tx           : byte-stream master (tx_data, tx_valid, tx_ready)
//   fifo_full    : buffer holds FIFO_DEPTH entries
//   drop_count   : nonces lost to overflow, saturating at 255
//   busy         : buffer non-empty or a frame in progress
// Build option NONCE_REPORT_HEADER_EN: prefixes each frame with header byte 0xA5 (5-byte frames).
module nonce_report_tx #(
    parameter int NUM_CORES  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [NUM_CORES-1:0]  flag,
    input  logic [31:0]           golden_nonce,
    nonce_report_tx_if.master     tx,
    output logic                  fifo_full,
    output logic [7:0]            drop_count,
    output logic                  busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);
`ifdef NONCE_REPORT_HEADER_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t         state, state_nx;
    logic           hit, hit_q, cap, push, pop, xfer, last, adv;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    occ;
    logic [31:0]    mem [FIFO_DEPTH];
    logic [31:0]    sh;
    logic [2:0]     idx;
    logic [7:0]     cur_byte;

    assign hit       = |flag;
    assign cap       = hit & ~hit_q;
    assign pop       = state == LOAD;
    assign fifo_full = occ == FULL_OCC;
    // a full buffer still accepts when the head leaves in the same cycle
    assign push      = cap & (~fifo_full | pop);
    assign xfer      = (state == SEND) & tx.tx_ready;
    assign last      = idx == LAST_IDX;
    assign busy      = (occ != '0) | (state != IDLE);

`ifdef NONCE_REPORT_HEADER_EN
    // the shift register only advances once the header byte has gone
    assign adv      = idx != 3'd0;
    assign cur_byte = (idx == 3'd0) ? 8'hA5 : sh[31:24];
`else
    assign adv      = 1'b1;
    assign cur_byte = sh[31:24];
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= golden_nonce;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hit_q      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            drop_count <= 8'h00;
        end else begin
            hit_q <= hit;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop)
                occ <= occ + 1'b1;
            else if (pop & ~push)
                occ <= occ - 1'b1;
            if (cap & fifo_full & ~pop & (drop_count != 8'hFF))
                drop_count <= drop_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sh  <= 32'h0;
            idx <= 3'd0;
        end else if (pop) begin
            sh  <= mem[rd_ptr];
            idx <= 3'd0;
        end else if (xfer) begin
            idx <= idx + 1'b1;
            if (adv)
                sh <= {sh[23:0], 8'h00};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && occ != '0)
            state_nx = LOAD;
        else if (state == LOAD)
            state_nx = SEND;
        else if (xfer && last)
            state_nx = (occ != '0) ? LOAD : IDLE;
    end

    always_comb begin
        tx.tx_valid = state == SEND;
        tx.tx_data  = (state == SEND) ? cur_byte : 8'h00;
    end
endmodule

// File: tb/tb_nonce_report_tx.sv
// tb_nonce_report_tx: scoreboard bench for nonce_report_tx; stimulus queues expected bytes, a monitor checks transfers.
module tb_nonce_report_tx;
    localparam int NC = 2;
`ifdef NONCE_REPORT_HEADER_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    logic          clk = 1'b0;
    logic          n_rst;
    logic [NC-1:0] flag;
    logic [31:0]   gn;
    logic          fifo_full;
    logic [7:0]    drop_count;
    logic          busy;
    int            checks = 0;
    int            errors = 0;
    logic [7:0]    exp_q [$];
    logic          stall_q = 1'b0;
    logic [7:0]    stall_d = 8'h00;
    logic [7:0]    first_byte;
    logic [31:0]   n;

    nonce_report_tx_if tx_if();

    nonce_report_tx #(.NUM_CORES(NC), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .flag         (flag),
        .golden_nonce (gn),
        .tx           (tx_if),
        .fifo_full    (fifo_full),
        .drop_count   (drop_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] v);
`ifdef NONCE_REPORT_HEADER_EN
        exp_q.push_back(8'hA5);
`endif
        for (int i = 3; i >= 0; i--)
            exp_q.push_back(v[8*i +: 8]);
    endtask

    task automatic pulse(input logic [31:0] v, input logic [NC-1:0] f, input bit expect_frame);
        @(posedge clk); #1;
        flag = f;
        gn   = v;
        if (expect_frame)
            push_frame(v);
        @(posedge clk); #1;
        flag = '0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !busy)
                return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got %0d bytes pending, busy %0b expected 0 pending, busy 0", name, exp_q.size(), busy);
    endtask

    always @(negedge clk) begin
        if (!n_rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && tx_if.tx_valid)
                check("hold_stable", tx_if.tx_data, stall_d);
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected no byte", tx_if.tx_data);
                end else begin
                    check("byte", tx_if.tx_data, exp_q.pop_front());
                end
            end
            stall_q = tx_if.tx_valid && !tx_if.tx_ready;
            stall_d = tx_if.tx_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef NONCE_REPORT_HEADER_EN
        first_byte = 8'hA5;
`else
        first_byte = 8'hDE;
`endif
        n_rst = 1'b0;
        flag  = '0;
        gn    = 32'h0;
        tx_if.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", tx_if.tx_valid, 0);
        check("rst_data", tx_if.tx_data, 0);
        check("rst_full", fifo_full, 0);
        check("rst_drop", drop_count, 0);
        check("rst_busy", busy, 0);
        n_rst = 1'b1;

        // single pulse, minimum latency and back-to-back bytes
        tx_if.tx_ready = 1'b1;
        pulse(32'hDEADBEEF, 2'b01, 1'b1);
        @(posedge clk); @(negedge clk);
        check("lat_load_valid", tx_if.tx_valid, 0);
        @(posedge clk); @(negedge clk);
        check("lat_first_valid", tx_if.tx_valid, 1);
        check("lat_first_data", tx_if.tx_data, first_byte);
        for (int i = 1; i < FRAME; i++) begin
            @(negedge clk);
            check("consecutive_valid", tx_if.tx_valid, 1);
        end
        wait_drain("single");

        // held flag gives one frame
        @(posedge clk); #1;
        flag = 2'b10;
        gn   = 32'h12345678;
        push_frame(32'h12345678);
        repeat (10) begin @(posedge clk); #1; end
        flag = '0;
        wait_drain("held");
        check("held_drop", drop_count, 0);

        // overflow with stalled sink
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n = 32'h10203040 + 32'(i) * 32'h01010101;
            pulse(n, 2'b01, i < 5);
        end
        check("ovf_full", fifo_full, 1);
        check("ovf_drop", drop_count, 1);
        check("ovf_busy", busy, 1);
        tx_if.tx_ready = 1'b1;
        wait_drain("ovf");

        // capture while full coinciding with LOAD pop
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n = 32'h55000000 + 32'(i) * 32'h00110011;
            pulse(n, 2'b10, 1'b1);
        end
        check("coin_full_before", fifo_full, 1);
        tx_if.tx_ready = 1'b1;
        repeat (FRAME - 1) begin @(posedge clk); #1; end
        pulse(32'h77665544, 2'b10, 1'b1);
        check("coin_full_after", fifo_full, 1);
        check("coin_drop", drop_count, 1);
        wait_drain("coin");

        // reset mid-frame
        tx_if.tx_ready = 1'b0;
        pulse(32'hCAFEF00D, 2'b01, 1'b0);
`ifdef NONCE_REPORT_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hCA);
`else
        exp_q.push_back(8'hCA);
        exp_q.push_back(8'hFE);
`endif
        pulse(32'h11111111, 2'b01, 1'b0);
        pulse(32'h22222222, 2'b01, 1'b0);
        tx_if.tx_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_rst = 1'b0;
        #1;
        check("abort_valid", tx_if.tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_drop", drop_count, 0);
        check("abort_full", fifo_full, 0);
        check("abort_sent", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort_quiet", busy, 0);

        // release with flag already high
        n_rst = 1'b0;
        flag  = 2'b01;
        gn    = 32'h0BADF00D;
        push_frame(32'h0BADF00D);
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        flag = '0;
        wait_drain("release");
        check("release_drop", drop_count, 0);

        // drop counter saturation
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n = 32'h90000000 + 32'(i);
            pulse(n, 2'b01, 1'b1);
        end
        for (int i = 0; i < 100; i++) pulse(32'hEE000000 + 32'(i), 2'b10, 1'b0);
        check("sat_100", drop_count, 100);
        for (int i = 0; i < 155; i++) pulse(32'hEF000000 + 32'(i), 2'b10, 1'b0);
        check("sat_255", drop_count, 255);
        for (int i = 0; i < 45; i++) pulse(32'hF0000000 + 32'(i), 2'b01, 1'b0);
        check("sat_300", drop_count, 255);
        check("sat_full", fifo_full, 1);
        tx_if.tx_ready = 1'b1;
        wait_drain("sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
